// File: rtl/reg32_tx_pkg.sv
// Shared types and constants for the 32-bit nibble transmitter.
// REG32_TX_CKSUM_EN adds the CKSUM state used for the checksum beat.
package reg32_tx_pkg;

    localparam int NIBBLES = 8;
    localparam int NIB_W   = 4;
    localparam int CNT_W   = 3;

`ifdef REG32_TX_CKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/reg32_tx_shift.sv
// 32-bit load/shift register presenting the current output nibble.
// Ports: clk, reset, load, shift, d[31:0] in; nib[3:0] out.
// MSB_FIRST=0 shifts right and presents d[3:0] first; MSB_FIRST=1
// shifts left and presents d[31:28] first. Vacated bits fill with 0.
module reg32_tx_shift
    import reg32_tx_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [31:0]      d,
    output logic [NIB_W-1:0] nib
);

    logic [31:0] sreg;

    // Load wins over shift so a word can follow the last beat directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                sreg <= {sreg[31-NIB_W:0], {NIB_W{1'b0}}};
            end else begin
                sreg <= {{NIB_W{1'b0}}, sreg[31:NIB_W]};
            end
        end
    end

    assign nib = (MSB_FIRST != 0) ? sreg[31 -: NIB_W] : sreg[NIB_W-1:0];

endmodule

// File: rtl/reg32_nibble_tx.sv
// Serialises a 32-bit word into eight 4-bit beats over valid/ready.
// Ports: clk, reset, d, load_valid -> load_ready; nib_q, nib_valid,
// nib_last -> nib_ready; busy. Optional REG32_TX_CKSUM_EN appends
// a ninth beat carrying the XOR of the eight data nibbles.
module reg32_nibble_tx
    import reg32_tx_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [NIB_W-1:0] nib_q,
    output logic             nib_valid,
    input  logic             nib_ready,
    output logic             nib_last,
    output logic             busy
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [NIB_W-1:0] sh_nib;
    logic             load_hs;
    logic             beat_hs;
    logic             shift_en;
    logic             end_of_data;

    reg32_tx_shift #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (load_hs),
        .shift (shift_en),
        .d     (d),
        .nib   (sh_nib)
    );

    assign nib_valid   = (state != IDLE);
    assign busy        = (state != IDLE);
    assign beat_hs     = nib_valid & nib_ready;
    assign shift_en    = beat_hs & (state == SEND);
    assign end_of_data = (state == SEND) && (cnt == CNT_W'(NIBBLES - 1));

`ifdef REG32_TX_CKSUM_EN
    logic [NIB_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load_hs) begin
            acc <= '0;
        end else if (shift_en) begin
            acc <= acc ^ sh_nib;
        end
    end

    assign nib_last = (state == CKSUM);
    assign nib_q    = (state == CKSUM) ? acc : sh_nib;
`else
    assign nib_last = end_of_data;
    assign nib_q    = sh_nib;
`endif

    // Accepting during the last beat lets the next word start with no bubble.
    assign load_ready = (state == IDLE) | (nib_last & nib_ready);
    assign load_hs    = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (load_hs) begin
                    state_nx = SEND;
                    cnt_nx   = '0;
                end
            end
            SEND: begin
                if (beat_hs) begin
                    if (end_of_data) begin
                        cnt_nx = '0;
`ifdef REG32_TX_CKSUM_EN
                        state_nx = CKSUM;
`else
                        state_nx = load_hs ? SEND : IDLE;
`endif
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
`ifdef REG32_TX_CKSUM_EN
            CKSUM: begin
                if (beat_hs) begin
                    state_nx = load_hs ? SEND : IDLE;
                    cnt_nx   = '0;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: doc/reg32_nibble_tx.md
REG32_NIBBLE_TX -- requirements
Module: reg32_nibble_tx

Interface
REQ-001 Parameter MSB_FIRST, default 0; 0 sends nibble d[3:0] first, 1 sends nibble d[31:28] first.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 d  input  32  parallel word to transmit; sampled only on load handshake.
REQ-005 load_valid  input  1  upstream offers d.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 nib_q  output  4  current output nibble.
REQ-008 nib_valid  output  1  nib_q holds a valid beat.
REQ-009 nib_ready  input  1  downstream accepts the beat this cycle.
REQ-010 nib_last  output  1  marks the final beat of a word.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Load handshake completes on a rising edge where load_valid and load_ready are both high; the captured word goes into a 32-bit shift register.
REQ-013 Beat handshake completes on a rising edge where nib_valid and nib_ready are both high.
REQ-014 FSM states: IDLE, SEND, CKSUM (CKSUM only when REQ-026 applies).
REQ-015 IDLE -> SEND on load handshake; nib_valid goes high the cycle after the load edge, so latency is 1 cycle.
REQ-016 In SEND, each beat handshake shifts the register by 4 bits toward the output end and increments a 3-bit beat counter (0..7).
REQ-017 nib_q, nib_valid and nib_last are held stable while nib_valid is high and nib_ready is low; once asserted, nib_valid is not dropped without a handshake.
REQ-018 nib_last is high on beat 7 of SEND when the checksum is compiled out, and only on the CKSUM beat when compiled in.
REQ-019 When the beat handshake completes on the beat carrying nib_last, the FSM goes to IDLE, unless a load handshake completes in the same cycle, in which case it goes to SEND with counter 0.
REQ-020 load_ready is high in IDLE, and is also high during the last beat when nib_ready is high (combinational), giving back-to-back words with no bubble; otherwise it is low.
REQ-021 The counter wraps from 7 to 0 only on a state transition; it never wraps mid-word.
REQ-022 A load_valid pulse while busy and load_ready is low is ignored; d is not captured.
REQ-023 nib_ready held high without nib_valid has no effect.

Reset
REQ-024 While reset is high at a rising edge: FSM = IDLE, counter = 0, shift register = 0, checksum accumulator = 0.
REQ-025 Reset values: nib_valid=0, nib_last=0, nib_q=4'h0, busy=0, load_ready=1 (from the cycle after reset). Reset mid-word aborts the word with no further beats; reset overrides a simultaneous load handshake.

Configuration
REQ-026 With REG32_TX_CKSUM_EN defined, SEND beat 7 moves the FSM to CKSUM, which emits one extra beat whose nib_q is the XOR of the 8 data nibbles with nib_last=1, giving 9 beats per word.
REQ-027 Without REG32_TX_CKSUM_EN, the CKSUM state and the accumulator are absent and each word is exactly 8 beats.

Structure
REQ-028 Package reg32_tx_pkg holds the FSM state typedef plus the constants NIBBLES=8, NIB_W=4 and CNT_W=3.
REQ-029 One sub-module, reg32_tx_shift, implements the 32-bit load/shift register with direction set by MSB_FIRST; the FSM, counter and checksum stay in the top level.

Verification
REQ-030 Load 32'h12345678 with MSB_FIRST=0 and nib_ready=1: beats are 8,7,6,5,4,3,2,1 on consecutive cycles starting 1 cycle after the load, with nib_last on beat 8.
REQ-031 Same word with REG32_TX_CKSUM_EN defined: a 9th beat 4'h8 with nib_last=1, and no nib_last on the 8th beat.
REQ-032 Load 32'hAFAFAFAF with MSB_FIRST=1 while nib_ready toggles 1,0,1,0: beats are A,F,A,F,... and nib_q is stable across every stall cycle.
REQ-033 Back-to-back: 32'hFFFFFFFF then 32'h00000000 offered continuously with nib_ready=1: 16 contiguous beats (F x8, 0 x8) with no idle cycle, and load_ready pulses only on each last beat.
REQ-034 Assert reset for 1 cycle after beat 3 of 32'hAFAFAFAF: the next cycle shows nib_valid=0, busy=0, load_ready=1, and the following load of 32'h12345678 transmits from beat 0.
REQ-035 Pulse load_valid with 32'hDEADBEEF mid-word: it is not captured and the current word completes unchanged.
